// File: rtl/mem_stage_bus_if.sv
// Memory-stage data-bus interface: runs req/ack load/store transactions,
// stalls the pipeline while they are in flight, and returns extended load data.
module mem_stage_bus_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_MemReadM,
    input  logic                     i_MemWriteM,
    input  logic [1:0]               i_MemSizeM,
    input  logic                     i_MemSignedM,
    input  logic [ADDRESS_WIDTH-1:0] i_ALUOutM,
    input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
    input  logic                     i_bus_ack,
    input  logic [DATA_WIDTH-1:0]    i_bus_rdata,
    output logic                     o_bus_req,
    output logic                     o_bus_we,
    output logic [ADDRESS_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0]    o_bus_wdata,
    output logic [3:0]               o_bus_be,
    output logic [DATA_WIDTH-1:0]    o_ReadDataM,
    output logic                     o_StallM,
    output logic                     o_MisalignM,
    output logic                     o_BusErrM
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;
    logic                  sgn_q;

    logic                  access;
    logic                  misalign;
    logic                  in_idle;
    logic                  start;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        access   = i_MemReadM | i_MemWriteM;
        in_idle  = (state == S_IDLE);
        misalign = 1'b0;
        if (i_MemSizeM == 2'b01)
            misalign = i_ALUOutM[0];
        else if (i_MemSizeM[1])
            misalign = |i_ALUOutM[1:0];
        start = in_idle & access & ~misalign;
    end

    // Gated by reset so nothing is requested of the pipeline while held in reset.
    assign o_MisalignM = i_rst_n & in_idle & access & misalign;
    assign o_StallM    = i_rst_n & (start | (state == S_REQ));

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = i_WriteDataM;
        if (i_MemSizeM == 2'b00) begin
            be_next    = 4'b0001 << i_ALUOutM[1:0];
            wdata_next = {4{i_WriteDataM[7:0]}};
        end else if (i_MemSizeM == 2'b01) begin
            be_next    = i_ALUOutM[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{i_WriteDataM[15:0]}};
        end
    end

    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = i_bus_rdata[7:0];
            2'd1:    byte_sel = i_bus_rdata[15:8];
            2'd2:    byte_sel = i_bus_rdata[23:16];
            default: byte_sel = i_bus_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        if (size_q == 2'b00)
            load_ext = {{24{sgn_q & byte_sel[7]}}, byte_sel};
        else if (size_q == 2'b01)
            load_ext = {{16{sgn_q & half_sel[15]}}, half_sel};
        else
            load_ext = i_bus_rdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_bus_be    <= '0;
            o_ReadDataM <= '0;
            o_BusErrM   <= 1'b0;
        end else begin
            o_BusErrM <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_MemWriteM;
                        o_bus_addr  <= {i_ALUOutM[ADDRESS_WIDTH-1:2], 2'b00};
                        o_bus_wdata <= wdata_next;
                        o_bus_be    <= be_next;
                        lane_q      <= i_ALUOutM[1:0];
                        size_q      <= i_MemSizeM;
                        sgn_q       <= i_MemSignedM;
                        cnt         <= '0;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + 1'b1;
                    // Ack is checked first so it wins over a coincident timeout.
                    if (i_bus_ack) begin
                        o_bus_req <= 1'b0;
                        if (!o_bus_we)
                            o_ReadDataM <= load_ext;
                        state <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        o_bus_req   <= 1'b0;
                        o_BusErrM   <= 1'b1;
                        o_ReadDataM <= '0;
                        state       <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_bus_if.sv
// Directed scoreboard bench for mem_stage_bus_if: loads, stores, misalign,
// timeout, ack-at-timeout boundary and mid-transaction reset.
module tb_mem_stage_bus_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_signed, bus_ack;
    logic [1:0]  mem_size;
    logic [31:0] alu_out, write_data, bus_rdata;
    logic        bus_req, bus_we, stall, misalign, bus_err;
    logic [31:0] bus_addr, bus_wdata, read_data;
    logic [3:0]  bus_be;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    mem_stage_bus_if #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(32),
        .TIMEOUT_CYCLES(16),
        .CNT_WIDTH(5)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_MemReadM(mem_read),
        .i_MemWriteM(mem_write),
        .i_MemSizeM(mem_size),
        .i_MemSignedM(mem_signed),
        .i_ALUOutM(alu_out),
        .i_WriteDataM(write_data),
        .i_bus_ack(bus_ack),
        .i_bus_rdata(bus_rdata),
        .o_bus_req(bus_req),
        .o_bus_we(bus_we),
        .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata),
        .o_bus_be(bus_be),
        .o_ReadDataM(read_data),
        .o_StallM(stall),
        .o_MisalignM(misalign),
        .o_BusErrM(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; mem_size = 2'b10; mem_signed = 0;
        alu_out = '0; write_data = '0; bus_ack = 0; bus_rdata = '0;
    endtask

    // ack_at = 0 means never acknowledge; expected bus fields come from the caller.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] rdata,
                              input logic [31:0] exp_load,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata);
        int stalls;
        logic [31:0] exp_rd;
        bit done;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_size = sz; mem_signed = sg;
        alu_out = addr; write_data = wd; bus_ack = 0; bus_rdata = '0;
        if (wr)            exp_rd = last_rd;
        else if (ack_at == 0) exp_rd = '0;
        else               exp_rd = exp_load;
        sb_q.push_back(exp_rd);
        #1;
        chk({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
        stalls = stall ? 1 : 0;
        done = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
            end else begin
                stalls++;
                if (cyc == 1) begin
                    chk({tag, "_req"},   {31'b0, bus_req}, 32'd1);
                    chk({tag, "_we"},    {31'b0, bus_we}, {31'b0, wr});
                    chk({tag, "_addr"},  bus_addr, exp_addr);
                    chk({tag, "_be"},    {28'b0, bus_be}, {28'b0, exp_be});
                    chk({tag, "_wdata"}, bus_wdata, exp_wdata);
                end
                bus_ack   = (cyc == ack_at);
                bus_rdata = (cyc == ack_at) ? rdata : 32'h5A5A_5A5A;
            end
        end
        chk({tag, "_done_seen"}, {31'b0, done}, 32'd1);
        chk({tag, "_stall_cycles"}, stalls, (ack_at == 0) ? 32'd17 : 32'(1 + ack_at));
        chk({tag, "_req_done"}, {31'b0, bus_req}, 32'd0);
        chk({tag, "_buserr"}, {31'b0, bus_err}, (ack_at == 0) ? 32'd1 : 32'd0);
        chk({tag, "_rdata"}, read_data, sb_q.pop_front());
        last_rd = read_data;
        idle_inputs();
        @(negedge clk);
        chk({tag, "_buserr_after"}, {31'b0, bus_err}, 32'd0);
        chk({tag, "_stall_after"}, {31'b0, stall}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, bus_req}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_be", {28'b0, bus_be}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst_n = 1;
        @(negedge clk);

        run_access("wload", 1, 0, 2'b10, 0, 32'h0000_0104, '0, 3, 32'hDEAD_BEEF,
                   32'hDEAD_BEEF, 32'h0000_0104, 4'b1111, 32'h0);
        run_access("sbyte", 1, 0, 2'b00, 1, 32'h0000_0003, '0, 1, 32'h80FF_0000,
                   32'hFFFF_FF80, 32'h0000_0000, 4'b1000, 32'h0);
        run_access("ubyte", 1, 0, 2'b00, 0, 32'h0000_0003, '0, 1, 32'h80FF_0000,
                   32'h0000_0080, 32'h0000_0000, 4'b1000, 32'h0);
        run_access("hstore", 0, 1, 2'b01, 0, 32'h0000_0012, 32'h1234_ABCD, 2, '0,
                   '0, 32'h0000_0010, 4'b1100, 32'hABCD_ABCD);
        run_access("bstore", 0, 1, 2'b00, 0, 32'h0000_0005, 32'h0000_00A5, 1, '0,
                   '0, 32'h0000_0004, 4'b0010, 32'hA5A5_A5A5);
        run_access("shalf_ack16", 1, 0, 2'b01, 1, 32'h0000_0002, '0, 16, 32'h8001_1234,
                   32'hFFFF_8001, 32'h0000_0000, 4'b1100, 32'h0);
        run_access("timeout", 1, 0, 2'b11, 0, 32'h0000_0020, '0, 0, '0,
                   '0, 32'h0000_0020, 4'b1111, 32'h0);

        // Misaligned word load: flagged, no request, no stall.
        @(negedge clk);
        mem_read = 1; mem_size = 2'b10; alu_out = 32'h0000_0002;
        #1;
        chk("mis_flag", {31'b0, misalign}, 32'd1);
        chk("mis_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        chk("mis_req", {31'b0, bus_req}, 32'd0);
        idle_inputs();

        // Reset during the second REQ cycle abandons the transaction.
        run_access("pre_rst", 1, 0, 2'b10, 0, 32'h0000_0040, '0, 1, 32'h1111_2222,
                   32'h1111_2222, 32'h0000_0040, 4'b1111, 32'h0);
        @(negedge clk);
        mem_read = 1; mem_size = 2'b10; alu_out = 32'h0000_0080;
        @(negedge clk);
        chk("mr_req1", {31'b0, bus_req}, 32'd1);
        @(negedge clk);
        chk("mr_req2", {31'b0, bus_req}, 32'd1);
        rst_n = 0;
        #1;
        chk("mr_req_async", {31'b0, bus_req}, 32'd0);
        chk("mr_stall", {31'b0, stall}, 32'd0);
        chk("mr_misalign", {31'b0, misalign}, 32'd0);
        chk("mr_addr", bus_addr, 32'd0);
        chk("mr_rdata", read_data, 32'd0);
        @(negedge clk);
        mem_read = 0;
        rst_n = 1;
        bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        chk("mr_ack_ignored_rdata", read_data, 32'd0);
        chk("mr_ack_ignored_req", {31'b0, bus_req}, 32'd0);
        chk("mr_ack_ignored_err", {31'b0, bus_err}, 32'd0);
        chk("mr_ack_ignored_stall", {31'b0, stall}, 32'd0);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
